core_sequencer: RTL and testbench

Multi-cycle sequencer for the RV32I core. It steps the single-cycle datapath and decoder through fetch, execute, memory and writeback phases, and drives valid/grant handshakes to the instruction and data memory ports. It gates the decoder's raw register-file and data-memory strobes so they fire exactly once per instruction. It also counts retired instructions and detects memory-port timeouts. It sits between the decode unit and the PC, IR and register file.

---
 rtl/core_seq_pkg.sv | 19 +
 rtl/core_sequencer_timeout_ctr.sv | 36 +++
 rtl/core_sequencer.sv | 144 ++++++++++++++
 tb/tb_core_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_seq_pkg.sv
// Shared types and defaults for the RV32I multi-cycle sequencer.
package core_seq_pkg;

   localparam int unsigned STATE_W         = 3;
   localparam int unsigned MEM_TIMEOUT_DEF = 255;
   localparam int unsigned CNT_W_DEF       = 32;

   typedef enum logic [STATE_W-1:0] {
      FETCH = 3'd0,
      IWAIT = 3'd1,
      EXEC  = 3'd2,
      MEM   = 3'd3,
      MWAIT = 3'd4,
      WB    = 3'd5,
      HALT  = 3'd6,
      FAULT = 3'd7
   } seq_state_t;

endpackage : core_seq_pkg

// File: rtl/core_sequencer_timeout_ctr.sv
// Cycle counter bounding how long a memory phase may wait for its slave.
module seq_timeout_ctr #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Saturates at LIMIT so an expired phase never aliases back to a small count.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !expired_o) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == CW'(LIMIT));

endmodule : seq_timeout_ctr

// File: rtl/core_sequencer.sv
// Multi-cycle phase sequencer: fetch/exec/mem/writeback control, handshakes,
// one-shot strobe gating, retired-instruction count and memory timeout.
module core_sequencer
   import core_seq_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
   parameter int unsigned CNT_W       = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             imem_req,
   input  logic             imem_gnt,
   input  logic             imem_rvalid,
   output logic             dmem_req,
   output logic             dmem_we,
   input  logic             dmem_gnt,
   input  logic             dmem_rvalid,
   input  logic             cu_rf_wen,
   input  logic             cu_dm_read,
   input  logic             cu_dm_wen,
   input  logic             cu_branch,
   input  logic             cu_jump,
   input  logic             branch_taken,
   input  logic             halt_req,
   output logic             ir_we,
   output logic             mdr_we,
   output logic             rf_wen,
   output logic             pc_we,
   output logic             pc_sel_target,
   output logic             halted,
   output logic             fault,
   output logic [CNT_W-1:0] instret,
   output logic [2:0]       state_o
);

   seq_state_t       state_q, state_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic             tmo_clr, tmo_en, tmo_expired;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= FETCH;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_d;
      end
   end

   // Next state; an expired timeout wins over any handshake in the same cycle.
   always_comb begin
      state_d   = state_q;
      instret_d = instret_q;
      case (state_q)
         FETCH: begin
            if (tmo_expired)   state_d = FAULT;
            else if (imem_gnt) state_d = IWAIT;
         end
         IWAIT: begin
            if (tmo_expired)      state_d = FAULT;
            else if (imem_rvalid) state_d = EXEC;
         end
         EXEC: begin
            state_d = (cu_dm_read || cu_dm_wen) ? MEM : WB;
         end
         MEM: begin
            if (tmo_expired)   state_d = FAULT;
            else if (dmem_gnt) state_d = MWAIT;
         end
         MWAIT: begin
            if (tmo_expired)      state_d = FAULT;
            else if (dmem_rvalid) state_d = WB;
         end
         WB: begin
            instret_d = instret_q + CNT_W'(1);
            state_d   = halt_req ? HALT : FETCH;
         end
         HALT: begin
            if (!halt_req) state_d = FETCH;
         end
         FAULT: begin
            state_d = FAULT;
         end
         default: begin
            state_d = FAULT;
         end
      endcase
   end

   // The timeout window restarts on entry to each port's request phase.
   always_comb begin
      tmo_clr = ((state_d == FETCH) && (state_q != FETCH)) ||
                ((state_d == MEM)   && (state_q != MEM));
      tmo_en  = (state_q == FETCH) || (state_q == IWAIT) ||
                (state_q == MEM)   || (state_q == MWAIT);
   end

   seq_timeout_ctr #(
      .LIMIT (MEM_TIMEOUT)
   ) u_tmo (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (tmo_clr),
      .en_i      (tmo_en),
      .expired_o (tmo_expired)
   );

   // Strobes decoded from state; held at zero for as long as reset is low.
   always_comb begin
      imem_req      = 1'b0;
      dmem_req      = 1'b0;
      dmem_we       = 1'b0;
      ir_we         = 1'b0;
      mdr_we        = 1'b0;
      rf_wen        = 1'b0;
      pc_we         = 1'b0;
      pc_sel_target = 1'b0;
      halted        = 1'b0;
      fault         = 1'b0;
      if (rst_n) begin
         case (state_q)
            FETCH: imem_req = 1'b1;
            IWAIT: ir_we    = imem_rvalid & ~tmo_expired;
            MEM: begin
               dmem_req = 1'b1;
               dmem_we  = cu_dm_wen;
            end
            MWAIT: mdr_we = dmem_rvalid & cu_dm_read & ~tmo_expired;
            WB: begin
               rf_wen        = cu_rf_wen & ~cu_dm_wen;
               pc_we         = 1'b1;
               pc_sel_target = cu_jump | (cu_branch & branch_taken);
            end
            HALT:    halted = 1'b1;
            FAULT:   fault  = 1'b1;
            default: ;
         endcase
      end
   end

   assign instret = rst_n ? instret_q : '0;
   assign state_o = rst_n ? 3'(state_q) : 3'd0;

endmodule : core_sequencer

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: main instance with default timeout,
// second instance with MEM_TIMEOUT=4 and a 2-bit counter for fault/wrap cases.
module tb_core_sequencer;

   localparam logic [9:0] IREQ = 10'b10_0000_0000;
   localparam logic [9:0] DREQ = 10'b01_0000_0000;
   localparam logic [9:0] DWE  = 10'b00_1000_0000;
   localparam logic [9:0] IRWE = 10'b00_0100_0000;
   localparam logic [9:0] MDR  = 10'b00_0010_0000;
   localparam logic [9:0] RFW  = 10'b00_0001_0000;
   localparam logic [9:0] PCW  = 10'b00_0000_1000;
   localparam logic [9:0] PCT  = 10'b00_0000_0100;
   localparam logic [9:0] HLT  = 10'b00_0000_0010;
   localparam logic [9:0] FLT  = 10'b00_0000_0001;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, imem_gnt, imem_rvalid, dmem_gnt, dmem_rvalid;
   logic cu_rf_wen, cu_dm_read, cu_dm_wen, cu_branch, cu_jump, branch_taken, halt_req;
   logic imem_req, dmem_req, dmem_we, ir_we, mdr_we, rf_wen, pc_we, pc_sel_target, halted, fault;
   logic [31:0] instret;
   logic [2:0]  state_o;

   logic t_rst_n, t_imem_gnt, t_imem_rvalid, t_dmem_gnt, t_dmem_rvalid;
   logic t_imem_req, t_dmem_req, t_dmem_we, t_ir_we, t_mdr_we, t_rf_wen, t_pc_we;
   logic t_pc_sel_target, t_halted, t_fault;
   logic [1:0] t_instret;
   logic [2:0] t_state_o;

   int passed = 0;
   int total  = 0;
   logic [1:0] wrap_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

   core_sequencer u_dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
      .cu_rf_wen(cu_rf_wen), .cu_dm_read(cu_dm_read), .cu_dm_wen(cu_dm_wen),
      .cu_branch(cu_branch), .cu_jump(cu_jump), .branch_taken(branch_taken),
      .halt_req(halt_req), .ir_we(ir_we), .mdr_we(mdr_we), .rf_wen(rf_wen),
      .pc_we(pc_we), .pc_sel_target(pc_sel_target), .halted(halted), .fault(fault),
      .instret(instret), .state_o(state_o)
   );

   core_sequencer #(.MEM_TIMEOUT(4), .CNT_W(2)) u_tmo (
      .clk(clk), .rst_n(t_rst_n),
      .imem_req(t_imem_req), .imem_gnt(t_imem_gnt), .imem_rvalid(t_imem_rvalid),
      .dmem_req(t_dmem_req), .dmem_we(t_dmem_we), .dmem_gnt(t_dmem_gnt), .dmem_rvalid(t_dmem_rvalid),
      .cu_rf_wen(cu_rf_wen), .cu_dm_read(cu_dm_read), .cu_dm_wen(cu_dm_wen),
      .cu_branch(cu_branch), .cu_jump(cu_jump), .branch_taken(branch_taken),
      .halt_req(halt_req), .ir_we(t_ir_we), .mdr_we(t_mdr_we), .rf_wen(t_rf_wen),
      .pc_we(t_pc_we), .pc_sel_target(t_pc_sel_target), .halted(t_halted), .fault(t_fault),
      .instret(t_instret), .state_o(t_state_o)
   );

   function automatic logic [31:0] mv();
      return 32'({state_o, imem_req, dmem_req, dmem_we, ir_we, mdr_we, rf_wen,
                  pc_we, pc_sel_target, halted, fault});
   endfunction

   function automatic logic [31:0] tv();
      return 32'({t_state_o, t_imem_req, t_dmem_req, t_dmem_we, t_ir_we, t_mdr_we, t_rf_wen,
                  t_pc_we, t_pc_sel_target, t_halted, t_fault});
   endfunction

   function automatic logic [31:0] ev(input logic [2:0] s, input logic [9:0] b);
      return 32'({s, b});
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic nx();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      #2;
   endtask

   task automatic set_cu(input logic rfw, input logic rd, input logic wr,
                         input logic br, input logic jp, input logic bt);
      cu_rf_wen = rfw; cu_dm_read = rd; cu_dm_wen = wr;
      cu_branch = br;  cu_jump = jp;    branch_taken = bt;
   endtask

   // Zero-wait fetch through EXEC on the main instance.
   task automatic fetch_exec(input string tag);
      imem_gnt = 1'b1;
      smp(); chk({tag, "_fetch"}, mv(), ev(3'd0, IREQ)); nx();
      imem_gnt = 1'b0; imem_rvalid = 1'b1;
      smp(); chk({tag, "_iwait"}, mv(), ev(3'd1, IRWE)); nx();
      imem_rvalid = 1'b0;
      smp(); chk({tag, "_exec"}, mv(), ev(3'd2, 10'd0)); nx();
   endtask

   task automatic run_nomem(input string tag, input logic [9:0] wb_exp);
      fetch_exec(tag);
      smp(); chk({tag, "_wb"}, mv(), ev(3'd5, wb_exp)); nx();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      halt_req = 1'b0; set_cu(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      t_rst_n = 1'b0; t_imem_gnt = 1'b0; t_imem_rvalid = 1'b0; t_dmem_gnt = 1'b0; t_dmem_rvalid = 1'b0;
      nx(); nx();
      smp();
      chk("rst_main", mv(), 32'd0);
      chk("rst_instret", instret, 32'd0);
      chk("rst_tmo", tv(), 32'd0);
      nx();

      rst_n = 1'b1; imem_gnt = 1'b0;
      smp(); chk("first_fetch", mv(), ev(3'd0, IREQ)); nx();

      // ADD, zero-wait
      set_cu(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_nomem("add", RFW | PCW);
      chk("add_instret", instret, 32'd1);

      // Load with three wait cycles on dmem_gnt: 9 cycles in total
      set_cu(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      fetch_exec("ld");
      for (int i = 0; i < 4; i++) begin
         dmem_gnt = (i == 3);
         smp(); chk("ld_mem", mv(), ev(3'd3, DREQ)); nx();
      end
      dmem_gnt = 1'b0; dmem_rvalid = 1'b1;
      smp(); chk("ld_mwait", mv(), ev(3'd4, MDR)); nx();
      dmem_rvalid = 1'b0;
      smp(); chk("ld_wb", mv(), ev(3'd5, RFW | PCW)); nx();
      chk("ld_instret", instret, 32'd2);

      // Store: dmem_we in MEM, no RF write in WB
      set_cu(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      fetch_exec("st");
      dmem_gnt = 1'b1;
      smp(); chk("st_mem", mv(), ev(3'd3, DREQ | DWE)); nx();
      dmem_gnt = 1'b0; dmem_rvalid = 1'b1;
      smp(); chk("st_mwait", mv(), ev(3'd4, 10'd0)); nx();
      dmem_rvalid = 1'b0;
      smp(); chk("st_wb", mv(), ev(3'd5, PCW)); nx();
      chk("st_instret", instret, 32'd3);

      // Stray rvalid in FETCH must not advance
      set_cu(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      imem_rvalid = 1'b1;
      smp(); chk("fetch_rvalid_ign", mv(), ev(3'd0, IREQ)); nx();
      imem_rvalid = 1'b0;
      run_nomem("beq_t", PCW | PCT);
      set_cu(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      run_nomem("beq_nt", PCW);
      set_cu(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      run_nomem("jalr", RFW | PCW | PCT);
      chk("br_instret", instret, 32'd6);

      // Halt raised in EXEC, with one IWAIT wait cycle
      set_cu(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      imem_gnt = 1'b1;
      smp(); chk("h_fetch", mv(), ev(3'd0, IREQ)); nx();
      imem_gnt = 1'b0;
      smp(); chk("h_iwait_wait", mv(), ev(3'd1, 10'd0)); nx();
      imem_rvalid = 1'b1;
      smp(); chk("h_iwait", mv(), ev(3'd1, IRWE)); nx();
      imem_rvalid = 1'b0; halt_req = 1'b1;
      smp(); chk("h_exec", mv(), ev(3'd2, 10'd0)); nx();
      smp(); chk("h_wb", mv(), ev(3'd5, RFW | PCW)); nx();
      imem_gnt = 1'b1; dmem_gnt = 1'b1;
      for (int i = 0; i < 2; i++) begin
         smp(); chk("h_halted", mv(), ev(3'd6, HLT)); nx();
      end
      imem_gnt = 1'b0; dmem_gnt = 1'b0; halt_req = 1'b0;
      smp(); chk("h_release", mv(), ev(3'd6, HLT)); nx();
      smp(); chk("h_refetch", mv(), ev(3'd0, IREQ));
      chk("h_instret", instret, 32'd7);
      nx();

      // Reset mid-fetch; late rvalid after reset is discarded
      imem_gnt = 1'b1;
      smp(); nx();
      imem_gnt = 1'b0; rst_n = 1'b0;
      smp(); chk("midrst_out", mv(), 32'd0); nx();
      rst_n = 1'b1; imem_rvalid = 1'b1;
      smp(); chk("midrst_fetch", mv(), ev(3'd0, IREQ));
      chk("midrst_instret", instret, 32'd0);
      nx();
      imem_rvalid = 1'b0;
      smp(); chk("midrst_late_rv", mv(), ev(3'd0, IREQ)); nx();

      // Timeout instance: imem_gnt never arrives
      t_rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         smp(); chk("tmo_fetch", tv(), ev(3'd0, IREQ)); nx();
      end
      t_imem_gnt = 1'b1;
      smp(); chk("tmo_fault", tv(), ev(3'd7, FLT)); nx();
      smp(); chk("tmo_sticky", tv(), ev(3'd7, FLT)); nx();
      t_imem_gnt = 1'b0; t_rst_n = 1'b0;
      smp(); chk("tmo_rst", tv(), 32'd0); nx();
      t_rst_n = 1'b1;

      // gnt in the expiring cycle is overridden by the fault
      for (int i = 0; i < 5; i++) begin
         t_imem_gnt = (i == 4);
         smp(); chk("ovr_fetch", tv(), ev(3'd0, IREQ)); nx();
      end
      t_imem_gnt = 1'b0;
      smp(); chk("ovr_fault", tv(), ev(3'd7, FLT)); nx();
      t_rst_n = 1'b0;
      nx();
      t_rst_n = 1'b1;

      // 2-bit retire counter wraps 3 -> 0, then reset clears it
      set_cu(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         t_imem_gnt = 1'b1; nx();
         t_imem_gnt = 1'b0; t_imem_rvalid = 1'b1; nx();
         t_imem_rvalid = 1'b0; nx();
         smp(); chk("wrap_wb", tv(), ev(3'd5, RFW | PCW)); nx();
         chk("wrap_instret", 32'(t_instret), 32'(wrap_exp[k]));
      end
      t_rst_n = 1'b0;
      nx();
      chk("tmo_rst_instret", 32'(t_instret), 32'd0);
      t_rst_n = 1'b1;
      smp(); chk("tmo_rst_fetch", tv(), ev(3'd0, IREQ)); nx();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_core_sequencer
